draw_arbiter: RTL and testbench
===============================

# draw_arbiter

Shares the single VGA plot port (`vga_adapter`) among up to `NUM_REQ` drawing clients: start screen, game-over screen, game background and moving sprites. Clients request a rectangular draw. The block grants one client at a time in round-robin order and scans the client's rectangle pixel by pixel, emitting local sprite-memory coordinates. It then adds the client's screen origin and drives `vga_x`/`vga_y`/`vga_colour`/`vga_plot`, suppressing transparent and off-screen pixels. It sits between the `control` FSM / sprite RAMs and the VGA adapter, replacing per-screen plotter instances.

## Interface
- `NUM_REQ`, 4, number of requesting clients (2..8)
- `WIDTH_X`, 8, screen/local x width
- `WIDTH_Y`, 7, screen/local y width
- `COLOR_W`, 3, colour width
- `TRANSP_EN`, 1, enable transparent-colour skipping
- `TRANSP_COLOR`, 3'b000, colour value treated as transparent

- `clk`  in  1  single system clock
- `resetn`  in  1  synchronous, active-low reset
- `req`  in  NUM_REQ  per-client draw request, level
- `org_x`  in  NUM_REQ*WIDTH_X  flattened screen origin x per client (client i at bits [i*WIDTH_X +: WIDTH_X])
- `org_y`  in  NUM_REQ*WIDTH_Y  flattened screen origin y per client
- `size_w`  in  NUM_REQ*WIDTH_X  flattened rectangle width per client
- `size_h`  in  NUM_REQ*WIDTH_Y  flattened rectangle height per client
- `spr_color`  in  COLOR_W  colour from the granted client's sprite RAM; valid 1 cycle after `spr_x`/`spr_y`
- `grant`  out  NUM_REQ  one-hot; current owner
- `done`  out  NUM_REQ  one-cycle pulse to the owner when its draw completes
- `spr_x`, `spr_y`  out  WIDTH_X, WIDTH_Y  local scan coordinates driven to the sprite RAMs
- `vga_x`, `vga_y`, `vga_colour`, `vga_plot`  out  WIDTH_X, WIDTH_Y, COLOR_W, 1  VGA adapter port
- `busy`  out  1  high in every state except IDLE

## Operation
- **States:** IDLE, SCAN, FLUSH, DONE.
- **IDLE:**
  - If any `req` bit is high, pick the winner: the first set bit at or after `ptr`, searching cyclically.
  - Latch the winner's org/size and move to SCAN with `grant[winner]` set.
  - If no `req` bit is high, stay in IDLE.
  - If the latched width or height is 0, go to DONE instead of SCAN; no pixels are plotted.
- **SCAN:**
  - One pixel per cycle, row-major: `spr_x` counts 0..w-1, then `spr_y` increments.
  - After the cycle holding (w-1, h-1), move to FLUSH.
- **FLUSH:** one cycle to emit the final pixel; then move to DONE.
- **DONE:**
  - Pulse `done[owner]` and deassert `grant`.
  - Set `ptr = (owner+1) mod NUM_REQ`; return to IDLE.
- **Pixel output:**
  - For coordinates issued in cycle k, `vga_x = org_x + spr_x` and `vga_y = org_y + spr_y`, registered so they appear in cycle k+1.
  - `vga_colour = spr_color` in cycle k+1.
  - `vga_plot` in cycle k+1 is 1 only if all of the following hold:
    - the pixel was issued in SCAN;
    - the sums have no carry out of WIDTH_X / WIDTH_Y (clipping: the pixel is dropped, never wrapped);
    - `TRANSP_EN` is 0, or `spr_color != TRANSP_COLOR`.
- **Request and input rules:**
  - A `req` drop mid-draw is ignored; the draw completes and `done` still pulses.
  - A client must drop `req` on `done`. If `req` is still high in IDLE, it is a new request.
  - Org/size inputs are sampled only at grant; later changes do not affect the current draw.
- **Reset (`resetn` = 0 at a clock edge, any state, including mid-scan):**
  - State goes to IDLE, `ptr` to 0, and all outputs to 0 (`grant`, `done`, `spr_*`, `vga_*`, `busy`).
  - No `done` pulse is issued for an aborted draw.

## Timing
- `req` is sampled high in IDLE at cycle 0. `grant`/`busy` rise at cycle 1.
- `spr_*` carries pixel n (0-based) in cycle 1+n; its `vga_*` output appears in cycle 2+n.
- FLUSH is cycle w·h+1, DONE (`done` pulse) is cycle w·h+2, and IDLE is cycle w·h+3.
- The earliest next grant is at cycle w·h+4. Per-draw overhead is 3 cycles; throughput is 1 pixel/cycle.
- Zero-size draw: grant at cycle 1 (DONE), `done` pulse at cycle 1, `vga_plot` never asserted.
- `grant` is stable and one-hot from SCAN through FLUSH, and low in IDLE and DONE.

## Structure
- Shared package `frogger_pkg`:
  - state encodings (`S_IDLE`, `S_SCAN`, `S_FLUSH`, `S_DONE`);
  - default `WIDTH_X`/`WIDTH_Y`/`COLOR_W`;
  - default `TRANSP_COLOR`.
- Sub-module `rr_select`, combinational: inputs `req` and `ptr`; outputs a one-hot winner and a valid flag.
- Scan counters, the origin adder with carry-based clip, and the output pipeline register stay in `draw_arbiter`.

## Test plan
- **Single client:** client 0 with org (10,5), size 3×2 and a RAM returning colour 3'b101.
  - `grant[0]` at cycle 1.
  - Six plots at (10,5), (11,5), (12,5), (10,6), (11,6), (12,6) in cycles 2–7.
  - `done[0]` at cycle 8.
- **Round-robin:** `req` = 4'b1011 held, each client releasing on its `done`. Grant order is 0, 1, 3, then 0 after re-request; never two bits of `grant` at once.
- **Transparency and clipping:**
  - RAM alternates 3'b000 / 3'b110 with `TRANSP_EN` = 1: only the 3'b110 pixels plot.
  - org_x = 254, w = 4 (`WIDTH_X` = 8): only x = 254 and 255 plot.
- **Zero size:** w = 0 gives a `done` pulse at cycle 1, no `vga_plot`, and IDLE at cycle 2.
- **Reset mid-scan:** `resetn` low during SCAN pixel 3 of 6.
  - Next cycle: all outputs 0, no `done`, `ptr` = 0.
  - A new `req` = 4'b0110 is granted to client 1 first.
- **Request drop mid-draw:** `req[2]` falls at pixel 1 of a 2×2 draw. All 4 pixels still plot and `done[2]` pulses.

Source files
------------

// File: rtl/frogger_pkg.sv
// rtl/frogger_pkg.sv - shared state encodings and default widths for the drawing path
package frogger_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SCAN  = 2'd1,
        S_FLUSH = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam int DEF_WIDTH_X = 8;
    localparam int DEF_WIDTH_Y = 7;
    localparam int DEF_COLOR_W = 3;

    localparam logic [DEF_COLOR_W-1:0] DEF_TRANSP_COLOR = 3'b000;

endpackage

// File: rtl/draw_arbiter_rr_select.sv
// rtl/draw_arbiter_rr_select.sv - combinational round-robin pick starting at ptr
module rr_select #(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] winner,
    output logic               valid
);

    logic [PTR_W-1:0] idx;

    always_comb begin
        winner = '0;
        valid  = 1'b0;
        idx    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = PTR_W'((int'(ptr) + i) % NUM_REQ);
            if (!valid && req[idx]) begin
                winner[idx] = 1'b1;
                valid       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/draw_arbiter.sv
// rtl/draw_arbiter.sv - round-robin owner of the VGA plot port, scans each client rectangle
module draw_arbiter
    import frogger_pkg::*;
#(
    parameter int                   NUM_REQ      = 4,
    parameter int                   WIDTH_X      = DEF_WIDTH_X,
    parameter int                   WIDTH_Y      = DEF_WIDTH_Y,
    parameter int                   COLOR_W      = DEF_COLOR_W,
    parameter bit                   TRANSP_EN    = 1'b1,
    parameter logic [COLOR_W-1:0]   TRANSP_COLOR = DEF_TRANSP_COLOR
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ*WIDTH_X-1:0] org_x,
    input  logic [NUM_REQ*WIDTH_Y-1:0] org_y,
    input  logic [NUM_REQ*WIDTH_X-1:0] size_w,
    input  logic [NUM_REQ*WIDTH_Y-1:0] size_h,
    input  logic [COLOR_W-1:0]         spr_color,
    output logic [NUM_REQ-1:0]         grant,
    output logic [NUM_REQ-1:0]         done,
    output logic [WIDTH_X-1:0]         spr_x,
    output logic [WIDTH_Y-1:0]         spr_y,
    output logic [WIDTH_X-1:0]         vga_x,
    output logic [WIDTH_Y-1:0]         vga_y,
    output logic [COLOR_W-1:0]         vga_colour,
    output logic                       vga_plot,
    output logic                       busy
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    state_t               state, state_nxt;
    logic [NUM_REQ-1:0]   owner;
    logic [PTR_W-1:0]     ptr, owner_idx;
    logic [NUM_REQ-1:0]   win_oh;
    logic                 win_valid;
    logic [WIDTH_X-1:0]   sel_ox, sel_w, lat_ox, lat_w;
    logic [WIDTH_Y-1:0]   sel_oy, sel_h, lat_oy, lat_h;
    logic                 last_x, last_y;
    logic [WIDTH_X:0]     sum_x;
    logic [WIDTH_Y:0]     sum_y;
    logic                 pix_valid, in_range;

    rr_select #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_rr_select (
        .req    (req),
        .ptr    (ptr),
        .winner (win_oh),
        .valid  (win_valid)
    );

    always_comb begin
        sel_ox    = '0;
        sel_oy    = '0;
        sel_w     = '0;
        sel_h     = '0;
        owner_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win_oh[i]) begin
                sel_ox = org_x[i*WIDTH_X +: WIDTH_X];
                sel_oy = org_y[i*WIDTH_Y +: WIDTH_Y];
                sel_w  = size_w[i*WIDTH_X +: WIDTH_X];
                sel_h  = size_h[i*WIDTH_Y +: WIDTH_Y];
            end
            if (owner[i]) begin
                owner_idx = PTR_W'(i);
            end
        end
    end

    assign last_x = (spr_x == lat_w - WIDTH_X'(1));
    assign last_y = (spr_y == lat_h - WIDTH_Y'(1));

    // Extra top bit catches the carry so off-screen pixels are dropped rather than wrapped.
    assign sum_x = {1'b0, lat_ox} + {1'b0, spr_x};
    assign sum_y = {1'b0, lat_oy} + {1'b0, spr_y};

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (win_valid) begin
                    state_nxt = (sel_w == '0 || sel_h == '0) ? S_DONE : S_SCAN;
                end
            end
            S_SCAN:  if (last_x && last_y) state_nxt = S_FLUSH;
            S_FLUSH: state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        grant      = (state == S_SCAN || state == S_FLUSH) ? owner : '0;
        done       = (state == S_DONE) ? owner : '0;
        busy       = (state != S_IDLE);
        vga_colour = pix_valid ? spr_color : '0;
        vga_plot   = pix_valid && in_range &&
                     (!TRANSP_EN || spr_color != TRANSP_COLOR);
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            owner     <= '0;
            ptr       <= '0;
            lat_ox    <= '0;
            lat_oy    <= '0;
            lat_w     <= '0;
            lat_h     <= '0;
            spr_x     <= '0;
            spr_y     <= '0;
            pix_valid <= 1'b0;
            in_range  <= 1'b0;
            vga_x     <= '0;
            vga_y     <= '0;
        end else begin
            if (state == S_IDLE && win_valid) begin
                owner  <= win_oh;
                lat_ox <= sel_ox;
                lat_oy <= sel_oy;
                lat_w  <= sel_w;
                lat_h  <= sel_h;
                spr_x  <= '0;
                spr_y  <= '0;
            end
            if (state == S_SCAN && !(last_x && last_y)) begin
                if (last_x) begin
                    spr_x <= '0;
                    spr_y <= spr_y + WIDTH_Y'(1);
                end else begin
                    spr_x <= spr_x + WIDTH_X'(1);
                end
            end
            if (state == S_DONE) begin
                ptr <= (owner_idx == PTR_W'(NUM_REQ - 1)) ? '0 : owner_idx + PTR_W'(1);
            end
            pix_valid <= (state == S_SCAN);
            in_range  <= !sum_x[WIDTH_X] && !sum_y[WIDTH_Y];
            vga_x     <= sum_x[WIDTH_X-1:0];
            vga_y     <= sum_y[WIDTH_Y-1:0];
        end
    end

endmodule

// File: tb/tb_draw_arbiter.sv
// tb/tb_draw_arbiter.sv - directed self-checking bench for draw_arbiter
module tb_draw_arbiter;

    localparam int NR = 4;
    localparam int WX = 8;
    localparam int WY = 7;
    localparam int CW = 3;

    logic              clk = 1'b0;
    logic              resetn;
    logic [NR-1:0]     req;
    logic [NR*WX-1:0]  org_x, size_w;
    logic [NR*WY-1:0]  org_y, size_h;
    logic [CW-1:0]     spr_color;
    logic [NR-1:0]     grant, done;
    logic [WX-1:0]     spr_x, vga_x;
    logic [WY-1:0]     spr_y, vga_y;
    logic [CW-1:0]     vga_colour;
    logic              vga_plot, busy;

    int errors = 0;
    int checks = 0;
    bit ram_mode = 1'b0;
    int px[$];
    int py[$];
    int pc[$];
    int g, d;

    draw_arbiter dut (
        .clk        (clk),
        .resetn     (resetn),
        .req        (req),
        .org_x      (org_x),
        .org_y      (org_y),
        .size_w     (size_w),
        .size_h     (size_h),
        .spr_color  (spr_color),
        .grant      (grant),
        .done       (done),
        .spr_x      (spr_x),
        .spr_y      (spr_y),
        .vga_x      (vga_x),
        .vga_y      (vga_y),
        .vga_colour (vga_colour),
        .vga_plot   (vga_plot),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Sprite RAM model: one-cycle read latency.
    always @(posedge clk) begin
        if (ram_mode) spr_color <= spr_x[0] ? 3'b110 : 3'b000;
        else          spr_color <= 3'b101;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic set_client(input int i, input int ox, input int oy, input int w, input int h);
        org_x[i*WX +: WX]  = WX'(ox);
        org_y[i*WY +: WY]  = WY'(oy);
        size_w[i*WX +: WX] = WX'(w);
        size_h[i*WY +: WY] = WY'(h);
    endtask

    function automatic int qget(input int q[$], input int i);
        return (i < q.size()) ? q[i] : -1;
    endfunction

    task automatic run_draw(input int owner, input int drop_after, output int g_cyc, output int d_cyc);
        logic [NR-1:0] oh;
        oh = NR'(1) << owner;
        g_cyc = -1;
        d_cyc = -1;
        px.delete(); py.delete(); pc.delete();
        for (int cyc = 1; cyc <= 300; cyc++) begin
            tick();
            if (vga_plot) begin
                px.push_back(int'(vga_x));
                py.push_back(int'(vga_y));
                pc.push_back(int'(vga_colour));
            end
            if (grant != '0) begin
                if (g_cyc < 0) g_cyc = cyc;
                check("grant_owner", grant, oh);
            end
            if (g_cyc >= 0 && drop_after >= 0 && cyc == g_cyc + drop_after) req[owner] = 1'b0;
            if (done != '0) begin
                check("done_owner", done, oh);
                req[owner] = 1'b0;
                d_cyc = cyc;
                break;
            end
        end
        check("draw_completed", d_cyc >= 0, 1);
    endtask

    initial begin
        resetn = 1'b0;
        req    = '0;
        org_x  = '0;
        org_y  = '0;
        size_w = '0;
        size_h = '0;
        tick();
        tick();
        check("rst_grant", grant, 0);
        check("rst_done", done, 0);
        check("rst_busy", busy, 0);
        check("rst_plot", vga_plot, 0);
        check("rst_spr_x", spr_x, 0);
        resetn = 1'b1;
        tick();

        // Round-robin: order 0,1,3, then 0 again after re-request
        for (int i = 0; i < NR; i++) set_client(i, 10 * i, i, 1, 1);
        req = 4'b1011;
        run_draw(0, -1, g, d);
        check("rr0_grant_cyc", g, 1);
        check("rr0_done_cyc", d, 3);
        run_draw(1, -1, g, d);
        run_draw(3, -1, g, d);
        check("rr3_plot_x", qget(px, 0), 30);
        req[0] = 1'b1;
        run_draw(0, -1, g, d);
        tick();

        // Single client 3x2 at (10,5)
        set_client(0, 10, 5, 3, 2);
        req = 4'b0001;
        tick();
        check("single_grant_c1", grant, 4'b0001);
        check("single_busy_c1", busy, 1);
        check("single_noplot_c1", vga_plot, 0);
        for (int n = 0; n < 6; n++) begin
            tick();
            check("single_plot", vga_plot, 1);
            check("single_x", vga_x, 10 + n % 3);
            check("single_y", vga_y, 5 + n / 3);
            check("single_col", vga_colour, 3'b101);
        end
        tick();
        check("single_done_c8", done, 4'b0001);
        check("single_grant_c8", grant, 0);
        req = '0;
        tick();
        check("single_idle_c9", busy, 0);

        // Transparency: only odd local x (colour 110) plots
        set_client(0, 0, 0, 4, 1);
        ram_mode = 1'b1;
        req = 4'b0001;
        run_draw(0, -1, g, d);
        check("transp_grant_cyc", g, 1);
        check("transp_done_cyc", d, 6);
        check("transp_count", px.size(), 2);
        check("transp_x0", qget(px, 0), 1);
        check("transp_x1", qget(px, 1), 3);
        check("transp_col", qget(pc, 0), 6);
        ram_mode = 1'b0;
        tick();

        // Clipping at the right edge
        set_client(0, 254, 0, 4, 1);
        req = 4'b0001;
        run_draw(0, -1, g, d);
        check("clip_count", px.size(), 2);
        check("clip_x0", qget(px, 0), 254);
        check("clip_x1", qget(px, 1), 255);
        tick();

        // Zero-size draw on client 2
        set_client(2, 5, 5, 0, 1);
        req = 4'b0100;
        tick();
        check("zero_done_c1", done, 4'b0100);
        check("zero_busy_c1", busy, 1);
        check("zero_grant_c1", grant, 0);
        check("zero_plot_c1", vga_plot, 0);
        req = '0;
        tick();
        check("zero_idle_c2", busy, 0);
        check("zero_plot_c2", vga_plot, 0);

        // Client 1 draw leaves ptr at 2 before the aborted draw
        req = 4'b0010;
        run_draw(1, -1, g, d);
        check("c1_done_cyc", d, 3);
        tick();

        // Reset during pixel 3 of a 3x2 draw
        set_client(0, 10, 5, 3, 2);
        req = 4'b0001;
        repeat (4) tick();
        check("abort_spr_x", spr_x, 0);
        check("abort_spr_y", spr_y, 1);
        resetn = 1'b0;
        req = '0;
        tick();
        check("abort_grant", grant, 0);
        check("abort_done", done, 0);
        check("abort_busy", busy, 0);
        check("abort_spr_x0", spr_x, 0);
        check("abort_spr_y0", spr_y, 0);
        check("abort_vga_x", vga_x, 0);
        check("abort_vga_y", vga_y, 0);
        check("abort_vga_col", vga_colour, 0);
        check("abort_plot", vga_plot, 0);

        resetn = 1'b1;
        set_client(1, 40, 50, 1, 1);
        set_client(2, 20, 30, 2, 2);
        req = 4'b0110;
        run_draw(1, -1, g, d);
        check("postrst_grant_cyc", g, 1);

        // req[2] drops at pixel 1; all four pixels still plot
        run_draw(2, 1, g, d);
        check("drop_count", px.size(), 4);
        check("drop_len", d - g, 5);
        check("drop_x3", qget(px, 3), 21);
        check("drop_y3", qget(py, 3), 31);
        tick();
        check("drop_idle", busy, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
